// File: rtl/hdmi_tx_link_seq_if.sv
// hdmi_tx_link_seq_if
//   Bundles the link-control signals of the TMDS transmit sequencer.
//   master : the side that drives enable, MMCM lock and raw HPD and observes
//            the sequencer outputs (register block / board wrapper / bench).
//   slave  : the sequencer itself.
//   Signals:
//     en_i, locked_i, hpd_i        control inputs to the sequencer
//     serdes_rst_o, idle_o,
//     video_en_o, ready_o          lane control / link status outputs
//     hpd_o                        debounced hot-plug level
//     state_o[2:0]                 current sequencer state encoding
interface hdmi_tx_link_seq_if;
  logic       en_i;
  logic       locked_i;
  logic       hpd_i;
  logic       serdes_rst_o;
  logic       idle_o;
  logic       video_en_o;
  logic       ready_o;
  logic       hpd_o;
  logic [2:0] state_o;

  modport master (
    output en_i, locked_i, hpd_i,
    input  serdes_rst_o, idle_o, video_en_o, ready_o, hpd_o, state_o
  );

  modport slave (
    input  en_i, locked_i, hpd_i,
    output serdes_rst_o, idle_o, video_en_o, ready_o, hpd_o, state_o
  );
endinterface

// File: rtl/hdmi_tx_link_seq.sv
// hdmi_tx_link_seq
//   Power-up and link sequencer for the HDMI/TMDS transmit path. Waits for a
//   qualified MMCM lock, releases the OSERDES lanes, sends a burst of control
//   symbols and only then lets pixel data through. Any loss of enable, sink
//   (debounced HPD) or lock drops the link back to a quiet state.
//   Ports:
//     clk   pixel clock, rising edge
//     rst   synchronous active-high reset
//     link  hdmi_tx_link_seq_if.slave
//           in : en_i, locked_i, hpd_i (raw, asynchronous)
//           out: serdes_rst_o, idle_o, video_en_o, ready_o, hpd_o, state_o
//   All outputs are flops; lane controls are decoded from the next state so
//   they change on the same edge as state_o.
module hdmi_tx_link_seq #(
  parameter int LOCK_WAIT_CYCLES    = 1024,
  parameter int SERDES_RST_CYCLES   = 16,
  parameter int CTRL_PERIOD_CYCLES  = 64,
  parameter int HPD_DEBOUNCE_CYCLES = 256
) (
  input  logic                clk,
  input  logic                rst,
  hdmi_tx_link_seq_if.slave   link
);

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  localparam int MAX_DWELL = max3(LOCK_WAIT_CYCLES, SERDES_RST_CYCLES, CTRL_PERIOD_CYCLES);
  localparam int CNT_W     = $clog2(MAX_DWELL) + 1;
  localparam int DEB_W     = $clog2(HPD_DEBOUNCE_CYCLES) + 1;

  localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'(LOCK_WAIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] SRST_LAST = CNT_W'(SERDES_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] CTRL_LAST = CNT_W'(CTRL_PERIOD_CYCLES - 1);
  localparam logic [DEB_W-1:0] DEB_LAST  = DEB_W'(HPD_DEBOUNCE_CYCLES - 1);

  typedef enum logic [2:0] {
    ST_OFF        = 3'd0,
    ST_WAIT_LOCK  = 3'd1,
    ST_SERDES_RST = 3'd2,
    ST_PREAMBLE   = 3'd3,
    ST_ACTIVE     = 3'd4
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               sync1_q, sync1_d;
  logic               sync2_q, sync2_d;
  logic               hpd_q, hpd_d;
  logic [DEB_W-1:0]   deb_q, deb_d;
  logic               serdes_rst_q, serdes_rst_d;
  logic               idle_q, idle_d;
  logic               video_en_q, video_en_d;
  logic               ready_q, ready_d;

  // HPD: two-flop synchronizer, then a persistence counter that only runs
  // while the synchronized level disagrees with the accepted level.
  always_comb begin
    sync1_d = link.hpd_i;
    sync2_d = sync1_q;
    hpd_d   = hpd_q;
    deb_d   = '0;
    if (sync2_q != hpd_q) begin
      if (deb_q == DEB_LAST) begin
        hpd_d = sync2_q;
      end else begin
        deb_d = deb_q + DEB_W'(1);
      end
    end
  end

  // Next state. Enable/sink loss outranks lock loss, so a simultaneous
  // disable and unlock lands in OFF.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_OFF: begin
        if (link.en_i && hpd_q) state_d = ST_WAIT_LOCK;
      end
      ST_WAIT_LOCK: begin
        if (!link.en_i || !hpd_q)                 state_d = ST_OFF;
        else if (link.locked_i && cnt_q == LOCK_LAST) state_d = ST_SERDES_RST;
      end
      ST_SERDES_RST: begin
        if (!link.en_i || !hpd_q)  state_d = ST_OFF;
        else if (!link.locked_i)   state_d = ST_WAIT_LOCK;
        else if (cnt_q == SRST_LAST) state_d = ST_PREAMBLE;
      end
      ST_PREAMBLE: begin
        if (!link.en_i || !hpd_q)  state_d = ST_OFF;
        else if (!link.locked_i)   state_d = ST_WAIT_LOCK;
        else if (cnt_q == CTRL_LAST) state_d = ST_ACTIVE;
      end
      ST_ACTIVE: begin
        if (!link.en_i || !hpd_q)  state_d = ST_OFF;
        else if (!link.locked_i)   state_d = ST_WAIT_LOCK;
      end
      default: state_d = ST_OFF;
    endcase
  end

  // Shared dwell counter: cleared on every state change; in WAIT_LOCK it
  // measures the current unbroken run of lock. OFF and ACTIVE have no dwell
  // limit, so the counter is parked at zero there and can never wrap.
  always_comb begin
    cnt_d = '0;
    if (state_d == state_q) begin
      case (state_q)
        ST_WAIT_LOCK:               cnt_d = link.locked_i ? cnt_q + CNT_W'(1) : '0;
        ST_SERDES_RST, ST_PREAMBLE: cnt_d = cnt_q + CNT_W'(1);
        default:                    cnt_d = '0;
      endcase
    end
  end

  // Output decode from the next state so outputs track state_o edge for edge.
  always_comb begin
    serdes_rst_d = 1'b1;
    idle_d       = 1'b1;
    video_en_d   = 1'b0;
    ready_d      = 1'b0;
    case (state_d)
      ST_PREAMBLE: begin
        serdes_rst_d = 1'b0;
      end
      ST_ACTIVE: begin
        serdes_rst_d = 1'b0;
        idle_d       = 1'b0;
        video_en_d   = 1'b1;
        ready_d      = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_OFF;
      cnt_q        <= '0;
      sync1_q      <= 1'b0;
      sync2_q      <= 1'b0;
      hpd_q        <= 1'b0;
      deb_q        <= '0;
      serdes_rst_q <= 1'b1;
      idle_q       <= 1'b1;
      video_en_q   <= 1'b0;
      ready_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      sync1_q      <= sync1_d;
      sync2_q      <= sync2_d;
      hpd_q        <= hpd_d;
      deb_q        <= deb_d;
      serdes_rst_q <= serdes_rst_d;
      idle_q       <= idle_d;
      video_en_q   <= video_en_d;
      ready_q      <= ready_d;
    end
  end

  assign link.state_o      = state_q;
  assign link.serdes_rst_o = serdes_rst_q;
  assign link.idle_o       = idle_q;
  assign link.video_en_o   = video_en_q;
  assign link.ready_o      = ready_q;
  assign link.hpd_o        = hpd_q;

endmodule
